// File: rtl/slc3_mem_pkg.sv
// slc3_mem_pkg: shared types and defaults for the SLC-3 memory access controller.
//   mem_state_e      - access FSM state encoding
//   RD_LAT_DEFAULT   - default BRAM read latency (cycles, including output register)
//   IO_ADDR_DEFAULT  - default memory-mapped I/O address
package slc3_mem_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdWait,
        StRdCap,
        StWr,
        StDone,
        StRelease
    } mem_state_e;

    localparam int unsigned RD_LAT_DEFAULT  = 2;
    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/mmio_hex_reg.sv
// mmio_hex_reg: memory-mapped display register behind the I/O address.
//   Clk   - clock, rising edge
//   Reset - asynchronous active-low reset, clears the register
//   load  - capture din on the next rising edge
//   din   - write data
//   hex   - register contents
module mmio_hex_reg #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] hex
);

    logic [DATA_W-1:0] hex_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            hex_q <= '0;
        end else if (load) begin
            hex_q <= din;
        end
    end

    assign hex = hex_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: services level-held read/write requests from the SLC-3 control unit,
// either against a synchronous BRAM or against the memory-mapped I/O address
// (reads return SW, writes optionally load the HEX display register).
//
// Build option: define MEM_ACCESS_HEX_EN to instantiate the HEX_Out register; otherwise
// HEX_Out is tied to 0 and I/O writes complete with no side effect.
//
// Ports:
//   Clk, Reset          - clock (rising edge) and asynchronous active-low reset
//   Mem_OE, Mem_WE      - level-held read / write requests (write wins if both high)
//   ADDR, Data_from_CPU - access address and write data, latched on accept
//   Data_to_CPU         - registered read data, held until the next read capture
//   Mem_Rdy             - one-cycle completion pulse
//   SW                  - switch inputs, returned by reads of IO_ADDR
//   bram_en, bram_we, bram_addr, bram_din, bram_dout - BRAM port
//   HEX_Out             - display register
module mem_access_ctrl
    import slc3_mem_pkg::*;
#(
    parameter int unsigned       ADDR_W  = 16,
    parameter int unsigned       DATA_W  = 16,
    parameter int unsigned       RD_LAT  = RD_LAT_DEFAULT,
    parameter logic [ADDR_W-1:0] IO_ADDR = ADDR_W'(IO_ADDR_DEFAULT)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Mem_OE,
    input  logic              Mem_WE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] Data_from_CPU,
    output logic [DATA_W-1:0] Data_to_CPU,
    output logic              Mem_Rdy,
    input  logic [DATA_W-1:0] SW,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [DATA_W-1:0] HEX_Out
);

    // RD_WAIT lasts lat_cnt_q+1 cycles, so load RD_LAT-1.
    localparam logic [2:0] LatLoad = 3'(RD_LAT - 1);

    mem_state_e        state_q;
    logic [2:0]        lat_cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              io_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rdy_q;
    logic              bram_en_q;
    logic              bram_we_q;
    logic              req_is_io;

    assign req_is_io = (ADDR == IO_ADDR);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= StIdle;
            lat_cnt_q <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            io_q      <= 1'b0;
            rd_data_q <= '0;
            rdy_q     <= 1'b0;
            bram_en_q <= 1'b0;
            bram_we_q <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a state re-asserts them.
            rdy_q     <= 1'b0;
            bram_en_q <= 1'b0;
            bram_we_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    addr_q <= ADDR;
                    data_q <= Data_from_CPU;
                    io_q   <= req_is_io;
                    if (Mem_WE) begin
                        state_q   <= StWr;
                        bram_en_q <= ~req_is_io;
                        bram_we_q <= ~req_is_io;
                    end else if (Mem_OE) begin
                        if (req_is_io) begin
                            state_q <= StRdCap;
                        end else begin
                            state_q   <= StRdWait;
                            bram_en_q <= 1'b1;
                            lat_cnt_q <= LatLoad;
                        end
                    end
                end
                StRdWait: begin
                    if (lat_cnt_q == 3'd0) begin
                        state_q <= StRdCap;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 3'd1;
                        bram_en_q <= 1'b1;
                    end
                end
                StRdCap: begin
                    rd_data_q <= io_q ? SW : bram_dout;
                    rdy_q     <= 1'b1;
                    state_q   <= StDone;
                end
                StWr: begin
                    rdy_q   <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    state_q <= StRelease;
                end
                StRelease: begin
                    // Wait for the control unit to drop the request so it is not re-serviced.
                    if (!Mem_OE && !Mem_WE) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign Data_to_CPU = rd_data_q;
    assign Mem_Rdy     = rdy_q;
    assign bram_en     = bram_en_q;
    assign bram_we     = bram_we_q;
    assign bram_addr   = addr_q;
    assign bram_din    = data_q;

`ifdef MEM_ACCESS_HEX_EN
    logic hex_load;
    assign hex_load = (state_q == StWr) && io_q;

    mmio_hex_reg #(
        .DATA_W(DATA_W)
    ) u_hex_reg (
        .Clk  (Clk),
        .Reset(Reset),
        .load (hex_load),
        .din  (data_q),
        .hex  (HEX_Out)
    );
`else
    assign HEX_Out = '0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: self-checking bench for mem_access_ctrl with a behavioural BRAM.
// Expected results are pushed to a scoreboard when a request is driven and compared when
// Mem_Rdy appears. Latency is the cycle number in which Mem_Rdy is high, counting the
// cycle right after the accept edge as cycle 1.
module tb_mem_access_ctrl;

    localparam int unsigned LAT   = 2;
    localparam logic [15:0] IOA   = 16'hFFFF;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Mem_OE = 1'b0;
    logic        Mem_WE = 1'b0;
    logic [15:0] ADDR = '0;
    logic [15:0] Data_from_CPU = '0;
    logic [15:0] Data_to_CPU;
    logic        Mem_Rdy;
    logic [15:0] SW = 16'h00A5;
    logic        bram_en;
    logic        bram_we;
    logic [15:0] bram_addr;
    logic [15:0] bram_din;
    logic [15:0] bram_dout;
    logic [15:0] HEX_Out;

    always #5 Clk = ~Clk;

    mem_access_ctrl #(
        .ADDR_W (16),
        .DATA_W (16),
        .RD_LAT (LAT),
        .IO_ADDR(IOA)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Mem_OE       (Mem_OE),
        .Mem_WE       (Mem_WE),
        .ADDR         (ADDR),
        .Data_from_CPU(Data_from_CPU),
        .Data_to_CPU  (Data_to_CPU),
        .Mem_Rdy      (Mem_Rdy),
        .SW           (SW),
        .bram_en      (bram_en),
        .bram_we      (bram_we),
        .bram_addr    (bram_addr),
        .bram_din     (bram_din),
        .bram_dout    (bram_dout),
        .HEX_Out      (HEX_Out)
    );

    // Behavioural BRAM: LAT-stage read pipeline, output register holds when idle.
    logic [15:0] bram [0:65535];
    logic [15:0] rd_pipe [0:LAT-1];

    always @(posedge Clk) begin
        if (bram_en && bram_we) bram[bram_addr] <= bram_din;
        if (bram_en) rd_pipe[0] <= bram[bram_addr];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign bram_dout = rd_pipe[LAT-1];

    // Reference model
    logic [15:0] ref_mem [0:65535];
    logic [15:0] ref_hex;

    typedef struct {
        string       tag;
        int          lat;
        logic [15:0] data;
        bit          is_rd;
        int          n_we;
        int          en_mode;  // 0: never high, 1: exactly one cycle, 2: at least one cycle
    } exp_t;

    exp_t sb[$];

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic access(input string tag, input bit oe, input bit we,
                          input logic [15:0] addr, input logic [15:0] data);
        exp_t e;
        exp_t r;
        bit   io;
        bit   got;
        int   cyc;
        int   en_cnt;
        int   we_cnt;
        int   rdy_cnt;

        io      = (addr == IOA);
        e.tag   = tag;
        e.is_rd = oe && !we;
        if (we) begin
            e.lat     = 2;
            e.data    = '0;
            e.n_we    = io ? 0 : 1;
            e.en_mode = io ? 0 : 1;
            if (!io) ref_mem[addr] = data;
`ifdef MEM_ACCESS_HEX_EN
            if (io) ref_hex = data;
`endif
        end else begin
            e.lat     = io ? 2 : LAT + 2;
            e.data    = io ? SW : ref_mem[addr];
            e.n_we    = 0;
            e.en_mode = io ? 0 : 2;
        end
        sb.push_back(e);

        @(posedge Clk); #1;
        Mem_OE = oe;
        Mem_WE = we;
        ADDR = addr;
        Data_from_CPU = data;
        cyc = 0;
        got = 1'b0;
        en_cnt = 0;
        we_cnt = 0;
        while (!got && cyc < 20) begin
            @(posedge Clk); #1;
            cyc++;
            // Inputs change after accept; the access must use the latched values.
            if (cyc == 1) begin
                ADDR = ~addr;
                Data_from_CPU = ~data;
            end
            en_cnt += int'(bram_en);
            we_cnt += int'(bram_we);
            if (Mem_Rdy) got = 1'b1;
        end
        if (!got) check_eq({tag, " rdy_seen"}, Mem_Rdy, 1);

        r = sb.pop_front();
        check_eq({r.tag, " latency"}, cyc, r.lat);
        if (r.is_rd) check_eq({r.tag, " rdata"}, Data_to_CPU, r.data);

        // Keep the request held: no second pulse, no further BRAM writes.
        rdy_cnt = 0;
        repeat (3) begin
            @(posedge Clk); #1;
            rdy_cnt += int'(Mem_Rdy);
            we_cnt  += int'(bram_we);
        end
        check_eq({r.tag, " extra_rdy"}, rdy_cnt, 0);
        check_eq({r.tag, " we_cycles"}, we_cnt, r.n_we);
        if (r.en_mode == 2) check_eq({r.tag, " en_seen"}, en_cnt > 0, 1);
        else check_eq({r.tag, " en_cycles"}, en_cnt, r.en_mode);
        if (r.is_rd) check_eq({r.tag, " rdata_hold"}, Data_to_CPU, r.data);

        Mem_OE = 1'b0;
        Mem_WE = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
    endtask

    initial begin : main
        logic [15:0] a;
        logic [15:0] d;
        int          rdy_cnt;

        for (int i = 0; i < 65536; i++) begin
            bram[i] = '0;
            ref_mem[i] = '0;
        end
        for (int i = 0; i < LAT; i++) rd_pipe[i] = '0;
        bram[16'h0003] = 16'h1234;
        ref_mem[16'h0003] = 16'h1234;
        ref_hex = '0;

        repeat (2) @(posedge Clk);
        #1;
        check_eq("rst Mem_Rdy", Mem_Rdy, 0);
        check_eq("rst Data_to_CPU", Data_to_CPU, 0);
        check_eq("rst bram_en", bram_en, 0);
        check_eq("rst bram_we", bram_we, 0);
        check_eq("rst HEX_Out", HEX_Out, 0);
        Reset = 1'b1;

        access("rd_mem_3", 1'b1, 1'b0, 16'h0003, 16'h0000);
        access("wr_mem_10", 1'b0, 1'b1, 16'h0010, 16'hBEEF);
        check_eq("bram_10", bram[16'h0010], 16'hBEEF);
        access("rd_mem_10", 1'b1, 1'b0, 16'h0010, 16'h0000);
        access("rd_io", 1'b1, 1'b0, IOA, 16'h0000);
        access("wr_io", 1'b0, 1'b1, IOA, 16'h0042);
        check_eq("hex_after_wr_io", HEX_Out, ref_hex);
        check_eq("bram_ffff", bram[16'hFFFF], ref_mem[16'hFFFF]);
        access("rdwr_5", 1'b1, 1'b1, 16'h0005, 16'h7777);
        check_eq("bram_5", bram[16'h0005], 16'h7777);
        access("rd_mem_5", 1'b1, 1'b0, 16'h0005, 16'h0000);

        for (int i = 0; i < 4; i++) begin
            a = 16'($urandom_range(32, 255));
            d = 16'($urandom);
            access("wr_rand", 1'b0, 1'b1, a, d);
            access("rd_rand", 1'b1, 1'b0, a, 16'h0000);
        end

        SW = 16'h5A3C;
        access("rd_io_sw2", 1'b1, 1'b0, IOA, 16'h0000);

        // Reset during RD_WAIT aborts the read.
        @(posedge Clk); #1;
        Mem_OE = 1'b1;
        ADDR = 16'h0003;
        @(posedge Clk); #1;
        #3 Reset = 1'b0;
        #1;
        ref_hex = '0;
        check_eq("abort Mem_Rdy", Mem_Rdy, 0);
        check_eq("abort Data_to_CPU", Data_to_CPU, 0);
        check_eq("abort bram_en", bram_en, 0);
        check_eq("abort bram_we", bram_we, 0);
        check_eq("abort HEX_Out", HEX_Out, ref_hex);
        Mem_OE = 1'b0;
        rdy_cnt = 0;
        repeat (2) begin
            @(posedge Clk); #1;
            rdy_cnt += int'(Mem_Rdy);
        end
        Reset = 1'b1;
        repeat (6) begin
            @(posedge Clk); #1;
            rdy_cnt += int'(Mem_Rdy);
        end
        check_eq("abort no_rdy", rdy_cnt, 0);
        access("rd_io_after_rst", 1'b1, 1'b0, IOA, 16'h0000);

        check_eq("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: address width.
REQ-002 SHALL have parameter DATA_W, default 16: data width.
REQ-003 SHALL have parameter RD_LAT, default 2, legal range 1..7: BRAM read latency in cycles, including the output register.
REQ-004 SHALL have parameter IO_ADDR, default 16'hFFFF: memory-mapped I/O address.
REQ-005 SHALL have one clock, Clk (input, 1): all state updates on its rising edge.
REQ-006 SHALL have Reset (input, 1): asynchronous, active-low.
REQ-007 SHALL have Mem_OE, Mem_WE (input, 1 each): level-held read and write requests from the control unit.
REQ-008 SHALL have ADDR (input, ADDR_W) and Data_from_CPU (input, DATA_W).
REQ-009 SHALL have Data_to_CPU (output, DATA_W, registered): read return data.
REQ-010 SHALL have Mem_Rdy (output, 1): one-cycle completion pulse.
REQ-011 SHALL have SW (input, DATA_W): switch inputs.
REQ-012 SHALL have bram_en, bram_we (output, 1 each), bram_addr (output, ADDR_W) and bram_din (output, DATA_W) as BRAM controls.
REQ-013 SHALL have bram_dout (input, DATA_W): BRAM read data.
REQ-014 SHALL have HEX_Out (output, DATA_W): display register (see REQ-034).

Function
REQ-015 SHALL implement FSM states IDLE, RD_WAIT, RD_CAP, WR, DONE and RELEASE.
REQ-016 In IDLE, SHALL latch ADDR and Data_from_CPU and accept a request when Mem_OE or Mem_WE is high.
REQ-017 If Mem_OE and Mem_WE are high in the same cycle, SHALL perform the write and ignore the read.
REQ-018 For a memory read (ADDR != IO_ADDR): IDLE -> RD_WAIT, asserting bram_en with the latched address.
REQ-019 SHALL hold RD_WAIT for RD_LAT cycles, counted by a 3-bit down-counter.
REQ-020 From RD_WAIT, SHALL go to RD_CAP, capture bram_dout into Data_to_CPU, then go to DONE.
REQ-021 For an I/O read (ADDR == IO_ADDR): IDLE -> RD_CAP, capturing SW with no BRAM access.
REQ-022 For a memory write: IDLE -> WR, asserting bram_en and bram_we for exactly one cycle, then DONE.
REQ-023 For an I/O write: IDLE -> WR, asserting no BRAM signals, then DONE.
REQ-024 SHALL assert Mem_Rdy only in DONE, for exactly one cycle; DONE -> RELEASE.
REQ-025 SHALL stay in RELEASE until Mem_OE and Mem_WE are both low, then go to IDLE, so a held request is never serviced twice.
REQ-026 Read latency, from the accept edge to Mem_Rdy high, SHALL be RD_LAT+2 cycles for memory and 2 cycles for I/O.
REQ-027 Write latency, from the accept edge to Mem_Rdy high, SHALL be 2 cycles.
REQ-028 Data_to_CPU SHALL hold its value until the next read capture.
REQ-029 SHALL keep ADDR and data latched for the whole access; input changes after accept SHALL be ignored.
REQ-030 bram_we SHALL never be high outside WR.

Reset
REQ-031 On Reset low, SHALL asynchronously enter IDLE, clear the latency counter and force Data_to_CPU, HEX_Out and Mem_Rdy to 0.
REQ-032 On Reset low, bram_en and bram_we SHALL go to 0 immediately.
REQ-033 Reset asserted mid-access SHALL abort it: no Mem_Rdy pulse, and no BRAM write if asserted before WR.

Configuration
REQ-034 With MEM_ACCESS_HEX_EN defined, an I/O write SHALL load Data_from_CPU into HEX_Out in WR.
REQ-035 Without MEM_ACCESS_HEX_EN, HEX_Out SHALL be tied to 0 and an I/O write SHALL complete with no side effect, keeping the same timing.

Structure
REQ-036 Package slc3_mem_pkg SHALL hold the state enum type, the IO_ADDR default and the RD_LAT default.
REQ-037 Sub-module mmio_hex_reg SHALL contain the HEX_Out register and SHALL be instantiated only under MEM_ACCESS_HEX_EN.

Verification
REQ-038 Preload BRAM[16'h0003]=16'h1234, pulse Reset low, hold Mem_OE with ADDR=3 -> Mem_Rdy at cycle 4 (RD_LAT=2), Data_to_CPU=16'h1234, exactly one Mem_Rdy pulse while Mem_OE is held.
REQ-039 Mem_WE with ADDR=16'h0010 and data 16'hBEEF, then a read of 16'h0010 -> single bram_we cycle, read returns 16'hBEEF.
REQ-040 SW=16'h00A5 and a read of 16'hFFFF -> Mem_Rdy at cycle 2, Data_to_CPU=16'h00A5, bram_en never high.
REQ-041 A write of 16'h0042 to 16'hFFFF -> HEX_Out=16'h0042 with MEM_ACCESS_HEX_EN defined; HEX_Out=0 and BRAM unchanged without it.
REQ-042 Mem_OE and Mem_WE high together at ADDR=5 with data 16'h7777 -> write performed, BRAM[5]=16'h7777.
REQ-043 Reset low during RD_WAIT -> IDLE in the same cycle, Mem_Rdy stays 0, Data_to_CPU=0.
